// File: rtl/lnc_pkg.sv
// Shared types and helpers for the nested loop index generator.
package lnc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Upper bound on NUM_LEVELS*COUNTER_WIDTH that lnc_level can slice from.
    localparam int unsigned LNC_MAX_BITS = 256;

    function automatic logic [LNC_MAX_BITS-1:0] lnc_level(
        input logic [LNC_MAX_BITS-1:0] vec,
        input int unsigned             idx,
        input int unsigned             width
    );
        logic [LNC_MAX_BITS-1:0] ones;
        logic [LNC_MAX_BITS-1:0] mask;
        ones = '1;
        mask = ~(ones << width);
        return (vec >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/loop_level_counter.sv
// One level of the loop nest: index register, latched bound and carry logic.
module loop_level_counter
    import lnc_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         step,
    input  logic         carry_in,
    input  logic [W-1:0] bound_in,
    output logic [W-1:0] value,
    output logic         carry_out
);

    logic [W-1:0] value_q, value_d;
    logic [W-1:0] bound_q, bound_d;
    logic         at_max;

    assign at_max    = (value_q == bound_q);
    assign carry_out = carry_in & at_max;
    assign value     = value_q;

    // Wrap goes through the at_max compare, so a bound of all-ones never relies on overflow.
    always_comb begin
        value_d = value_q;
        bound_d = bound_q;
        if (clr) begin
            value_d = '0;
            bound_d = '0;
        end else if (load) begin
            value_d = '0;
            bound_d = bound_in;
        end else if (step && carry_in) begin
            value_d = at_max ? '0 : value_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            bound_q <= '0;
        end else begin
            value_q <= value_d;
            bound_q <= bound_d;
        end
    end

endmodule

// File: rtl/loop_nest_counter.sv
// Nested loop index generator: per-level counters chained by carry, with
// start/run sequencing and a one-cycle Done pulse after the final tuple.
module loop_nest_counter
    import lnc_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned NUM_LEVELS    = 3
) (
    input  logic                                CLK,
    input  logic                                ASYNC_RST,
    input  logic                                SYNC_RST,
    input  logic                                Start,
    input  logic                                EN,
    input  logic [NUM_LEVELS*COUNTER_WIDTH-1:0] MaxNumber,
    output logic                                Busy,
    output logic [NUM_LEVELS*COUNTER_WIDTH-1:0] Value,
    output logic [NUM_LEVELS-1:0]               Wrap,
    output logic                                Done
);

    state_e state_q, state_d;
    logic   done_q, done_d;
    logic   load;
    logic   run_step;
    logic [NUM_LEVELS:0] carry;

    assign run_step = (state_q == RUN) && EN;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_level
        logic [COUNTER_WIDTH-1:0] bound_in;
        logic [COUNTER_WIDTH-1:0] level_value;

        assign bound_in = COUNTER_WIDTH'(lnc_level(LNC_MAX_BITS'(MaxNumber), i, COUNTER_WIDTH));

        loop_level_counter #(
            .W(COUNTER_WIDTH)
        ) u_level (
            .clk      (CLK),
            .rst      (ASYNC_RST),
            .clr      (SYNC_RST),
            .load     (load),
            .step     (run_step),
            .carry_in (carry[i]),
            .bound_in (bound_in),
            .value    (level_value),
            .carry_out(carry[i+1])
        );

        assign Value[i*COUNTER_WIDTH +: COUNTER_WIDTH] = level_value;
        // carry[i+1] already equals carry[i] & at_max[i].
        assign Wrap[i] = run_step & carry[i+1];
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        if (SYNC_RST) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (run_step && carry[NUM_LEVELS]) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign Done = done_q;

endmodule

// File: tb/tb_loop_nest_counter.sv
// Directed bench for loop_nest_counter with two 4-bit levels.
module tb_loop_nest_counter;

    localparam int unsigned W  = 4;
    localparam int unsigned NL = 2;

    logic          CLK = 1'b0;
    logic          ASYNC_RST;
    logic          SYNC_RST;
    logic          Start;
    logic          EN;
    logic [NL*W-1:0] MaxNumber;
    logic          Busy;
    logic [NL*W-1:0] Value;
    logic [NL-1:0] Wrap;
    logic          Done;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    loop_nest_counter #(
        .COUNTER_WIDTH(W),
        .NUM_LEVELS   (NL)
    ) dut (
        .CLK      (CLK),
        .ASYNC_RST(ASYNC_RST),
        .SYNC_RST (SYNC_RST),
        .Start    (Start),
        .EN       (EN),
        .MaxNumber(MaxNumber),
        .Busy     (Busy),
        .Value    (Value),
        .Wrap     (Wrap),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       start;
        logic       en;
        logic       srst;
        logic [7:0] max;
        logic       ebusy;
        logic [7:0] evalue;
        logic [1:0] ewrap;
        logic       edone;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic e, input logic r, input logic [7:0] m,
                                input logic b, input logic [7:0] v, input logic [1:0] w,
                                input logic d);
        vec_t t;
        t.start = s; t.en = e; t.srst = r; t.max = m;
        t.ebusy = b; t.evalue = v; t.ewrap = w; t.edone = d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic b, input logic [7:0] v,
                             input logic [1:0] w, input logic d);
        chk({tag, " busy"},  32'(Busy),  32'(b));
        chk({tag, " value"}, 32'(Value), 32'(v));
        chk({tag, " wrap"},  32'(Wrap),  32'(w));
        chk({tag, " done"},  32'(Done),  32'(d));
    endtask

    task automatic drive(input logic s, input logic e, input logic r, input logic [7:0] m);
        @(posedge CLK);
        #1;
        Start = s; EN = e; SYNC_RST = r; MaxNumber = m;
    endtask

    logic [7:0] seq6 [6];

    initial begin
        ASYNC_RST = 1'b1; SYNC_RST = 1'b0; Start = 1'b0; EN = 1'b0; MaxNumber = '0;
        seq6[0] = 8'h00; seq6[1] = 8'h01; seq6[2] = 8'h10;
        seq6[3] = 8'h11; seq6[4] = 8'h20; seq6[5] = 8'h21;

        //              st en sr max    busy value  wrap   done
        // reset state and basic run with bounds {L1=2, L0=1}
        tbl.push_back(mk(0, 0, 0, 8'h21, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 8'h21, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 1, 8'h00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 1, 8'h01, 2'b01, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 1, 8'h10, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 1, 8'h11, 2'b01, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 1, 8'h20, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 1, 8'h21, 2'b11, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 0, 8'h00, 2'b00, 1));
        tbl.push_back(mk(0, 0, 0, 8'h21, 0, 8'h00, 2'b00, 0));
        // all bounds zero, then back-to-back Start during Done
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h00, 2'b11, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 2'b00, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h00, 2'b11, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 2'b00, 1));
        // SYNC_RST mid-run at (1,0): no Done, back to IDLE
        tbl.push_back(mk(1, 0, 0, 8'h21, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 1, 8'h00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 1, 8'h01, 2'b01, 0));
        tbl.push_back(mk(0, 1, 1, 8'h21, 1, 8'h10, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(1, 0, 1, 8'h21, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 8'h21, 0, 8'h00, 2'b00, 0));
        // Start and new MaxNumber during RUN are ignored
        tbl.push_back(mk(1, 0, 0, 8'h21, 0, 8'h00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, 8'h55, 1, 8'h00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, 8'h55, 1, 8'h01, 2'b01, 0));
        tbl.push_back(mk(1, 1, 0, 8'h55, 1, 8'h10, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, 8'h55, 1, 8'h11, 2'b01, 0));
        tbl.push_back(mk(1, 1, 0, 8'h55, 1, 8'h20, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, 8'h55, 1, 8'h21, 2'b11, 0));
        tbl.push_back(mk(0, 0, 0, 8'h55, 0, 8'h00, 2'b00, 1));

        #12 ASYNC_RST = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k].start, tbl[k].en, tbl[k].srst, tbl[k].max);
            @(negedge CLK);
            check_all($sformatf("row%0d", k), tbl[k].ebusy, tbl[k].evalue, tbl[k].ewrap, tbl[k].edone);
        end

        // EN pattern 1,0,0: Value holds on idle cycles, Done after six EN-high cycles
        drive(1, 0, 0, 8'h21);
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0, 8'h21);
            @(negedge CLK);
            check_all($sformatf("tog%0d_en", k), 1'b1, seq6[k],
                      (k % 2 == 1) ? ((k == 5) ? 2'b11 : 2'b01) : 2'b00, 1'b0);
            for (int h = 0; h < 2; h++) begin
                drive(0, 0, 0, 8'h21);
                @(negedge CLK);
                check_all($sformatf("tog%0d_hold%0d", k, h), (k != 5),
                          (k == 5) ? 8'h00 : seq6[k+1], 2'b00, (k == 5 && h == 0));
            end
        end

        // bound 15 on level 0: natural 4-bit wrap must go through at_max, 32 steps total
        drive(1, 0, 0, 8'h1F);
        for (int s = 0; s < 32; s++) begin
            drive(0, 1, 0, 8'h1F);
            @(negedge CLK);
            check_all($sformatf("wide%0d", s), 1'b1, 8'(s),
                      {(s == 31), (s % 16 == 15)}, 1'b0);
        end
        drive(0, 0, 0, 8'h1F);
        @(negedge CLK);
        check_all("wide_done", 1'b0, 8'h00, 2'b00, 1'b1);

        // ASYNC_RST between edges clears immediately
        drive(1, 0, 0, 8'h21);
        drive(0, 1, 0, 8'h21);
        drive(0, 1, 0, 8'h21);
        drive(0, 0, 0, 8'h21);
        #1;
        check_all("arst_before", 1'b1, 8'h10, 2'b00, 1'b0);
        ASYNC_RST = 1'b1;
        #1;
        check_all("arst_during", 1'b0, 8'h00, 2'b00, 1'b0);
        ASYNC_RST = 1'b0;
        drive(0, 1, 0, 8'h21);
        @(negedge CLK);
        check_all("arst_after", 1'b0, 8'h00, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
